// File: rtl/traffic_pkg.sv
// Shared definitions for the highway/country traffic sequencer:
// state encodings, one-hot light codes, default durations and light decode.
package traffic_pkg;

  // State encodings. Adjacent states differ by one bit.
  localparam logic [1:0] ST_HG = 2'b00;  // highway green
  localparam logic [1:0] ST_HY = 2'b01;  // highway yellow
  localparam logic [1:0] ST_SG = 2'b11;  // side (country) green
  localparam logic [1:0] ST_SY = 2'b10;  // side (country) yellow

  // One-hot {R,Y,G} light codes
  localparam logic [2:0] LIGHT_R = 3'b100;
  localparam logic [2:0] LIGHT_Y = 3'b010;
  localparam logic [2:0] LIGHT_G = 3'b001;

  // Default durations in seconds
  localparam logic [3:0] DEF_COUNTRY_SEC = 4'd5;
  localparam logic [3:0] DEF_YELLOW_SEC  = 4'd3;
  localparam logic [3:0] HWY_MIN_SEC     = 4'd10;

  typedef struct packed {
    logic [2:0] highway;
    logic [2:0] country;
  } lights_t;

  // A zero duration would make a state vanish; treat it as one second.
  function automatic logic [3:0] clamp_dur(input logic [3:0] d);
    return (d == 4'd0) ? 4'd1 : d;
  endfunction

  // Light pattern shown in each state
  function automatic lights_t decode_lights(input logic [1:0] st);
    lights_t l;
    case (st)
      ST_HG:   begin l.highway = LIGHT_G; l.country = LIGHT_R; end
      ST_HY:   begin l.highway = LIGHT_Y; l.country = LIGHT_R; end
      ST_SG:   begin l.highway = LIGHT_R; l.country = LIGHT_G; end
      ST_SY:   begin l.highway = LIGHT_R; l.country = LIGHT_Y; end
      default: begin l.highway = LIGHT_G; l.country = LIGHT_R; end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// One-second prescaler: counts 0..TICK_DIV-1 and pulses tick for one cycle
// at the top count. clear restarts the count so a new state gets a full
// first second.
module tick_gen #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  // Free-running modulo-TICK_DIV counter with synchronous restart
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear || (count == LAST)) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/traffic_sequencer.sv
// Highway/country-road traffic light sequencer. The highway stays green
// until a country car is seen and the minimum green time has elapsed; the
// country road gets green until its car leaves or its time runs out.
//
// Configuration strobe: data_country/data_yellow are captured on any rising
// edge with load=1 (no handshake, always accepted). Captured values wait in
// pending registers and become active only when a state transition is
// taken, so a running state never sees its duration change.
module traffic_sequencer
  import traffic_pkg::*;
#(
  parameter int         TICK_DIV    = 50000000,
  parameter logic [3:0] HWY_MIN     = HWY_MIN_SEC,
  parameter logic [3:0] DEF_COUNTRY = DEF_COUNTRY_SEC,
  parameter logic [3:0] DEF_YELLOW  = DEF_YELLOW_SEC
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] data_country,
  input  logic [3:0] data_yellow,
  input  logic       car,
  output logic [1:0] state,
  output logic [2:0] highway_light,
  output logic [2:0] country_light,
  output logic [3:0] current_time
);

  logic       car_meta;
  logic       car_sync;
  logic       tick;
  logic       take;
  logic [1:0] next_state;
  logic [3:0] pend_country, pend_yellow;
  logic [3:0] act_country, act_yellow;
  logic [3:0] load_country, load_yellow;
  lights_t    lights;

  assign load_country = clamp_dur(data_country);
  assign load_yellow  = clamp_dur(data_yellow);

  // Two-flop synchronizer for the asynchronous car sensor
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      car_meta <= 1'b0;
      car_sync <= 1'b0;
    end else begin
      car_meta <= car;
      car_sync <= car_meta;
    end
  end

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clock (clock),
    .reset (reset),
    .clear (take),
    .tick  (tick)
  );

  // Transition conditions, evaluated every cycle from the registered state
  always_comb begin
    next_state = state;
    case (state)
      ST_HG: if (car_sync && (current_time >= HWY_MIN))       next_state = ST_HY;
      ST_HY: if (current_time >= act_yellow)                  next_state = ST_SG;
      ST_SG: if (!car_sync || (current_time >= act_country))  next_state = ST_SY;
      ST_SY: if (current_time >= act_yellow)                  next_state = ST_HG;
      default:                                                next_state = ST_HG;
    endcase
  end

  assign take = (next_state != state);

  // State register and seconds-in-state counter; a transition wins over a tick
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= ST_HG;
      current_time <= 4'd0;
    end else if (take) begin
      state        <= next_state;
      current_time <= 4'd0;
    end else if (tick && (current_time != 4'd15)) begin
      current_time <= current_time + 4'd1;
    end
  end

  // Pending/active duration registers; a load coinciding with a transition
  // goes straight into the state being entered
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend_country <= DEF_COUNTRY;
      pend_yellow  <= DEF_YELLOW;
      act_country  <= DEF_COUNTRY;
      act_yellow   <= DEF_YELLOW;
    end else begin
      if (load) begin
        pend_country <= load_country;
        pend_yellow  <= load_yellow;
      end
      if (take) begin
        act_country <= load ? load_country : pend_country;
        act_yellow  <= load ? load_yellow  : pend_yellow;
      end
    end
  end

  assign lights        = decode_lights(state);
  assign highway_light = lights.highway;
  assign country_light = lights.country;

endmodule

// File: tb/tb_traffic_sequencer.sv
// Bench for traffic_sequencer: directed scenarios with hand-computed
// durations, then randomized car/load/reset traffic, all checked every
// cycle against a seconds-from-elapsed-cycles reference model.
module tb_traffic_sequencer;

  localparam int         TICK = 4;
  localparam logic [3:0] HMIN = 4'd2;

  logic       clock = 1'b0;
  logic       reset;
  logic       load;
  logic       car;
  logic [3:0] data_country;
  logic [3:0] data_yellow;
  logic [1:0] state;
  logic [2:0] highway_light;
  logic [2:0] country_light;
  logic [3:0] current_time;

  int n_checks = 0;
  int n_fail   = 0;

  traffic_sequencer #(.TICK_DIV(TICK), .HWY_MIN(HMIN)) dut (
    .clock         (clock),
    .reset         (reset),
    .load          (load),
    .data_country  (data_country),
    .data_yellow   (data_yellow),
    .car           (car),
    .state         (state),
    .highway_light (highway_light),
    .country_light (country_light),
    .current_time  (current_time)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // Watchdog so the run can never hang
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Phase index walks HG,HY,SG,SY in order. Seconds in state are derived
  // from the number of clock edges spent in the state.
  logic [1:0] st_code [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  logic [2:0] hw_code [4] = '{3'b001, 3'b010, 3'b100, 3'b100};
  logic [2:0] cy_code [4] = '{3'b100, 3'b100, 3'b001, 3'b010};

  int m_idx     = 0;
  int m_cycles  = 0;
  int m_country = 5;
  int m_yellow  = 3;
  int p_country = 5;
  int p_yellow  = 3;
  bit car_line[$];
  bit m_cs;
  bit m_go;
  int m_t;

  function automatic int fix_dur(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  function automatic int secs(input int cyc);
    int s;
    s = cyc / TICK;
    return (s > 15) ? 15 : s;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_idx = 0; m_cycles = 0;
      m_country = 5; m_yellow = 3; p_country = 5; p_yellow = 3;
      car_line = '{1'b0, 1'b0};
    end else begin
      m_cs = car_line[0];
      m_t  = secs(m_cycles);
      case (m_idx)
        0:       m_go = m_cs && (m_t >= int'(HMIN));
        1:       m_go = (m_t >= m_yellow);
        2:       m_go = !m_cs || (m_t >= m_country);
        default: m_go = (m_t >= m_yellow);
      endcase
      if (load) begin
        p_country = fix_dur(int'(data_country));
        p_yellow  = fix_dur(int'(data_yellow));
      end
      if (m_go) begin
        m_idx = (m_idx + 1) % 4;
        m_cycles = 0;
        m_country = p_country;
        m_yellow  = p_yellow;
      end else if (m_cycles < 1000) begin
        m_cycles++;
      end
      car_line.push_back(car);
      void'(car_line.pop_front());
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clock) begin
    check("state", int'(state), int'(st_code[m_idx]));
    check("highway_light", int'(highway_light), int'(hw_code[m_idx]));
    check("country_light", int'(country_light), int'(cy_code[m_idx]));
    check("current_time", int'(current_time), secs(m_cycles));
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic wait_state(input logic [1:0] code, input int max, output int n);
    n = 0;
    while ((state !== code) && (n < max)) begin
      @(posedge clock);
      #2;
      n++;
    end
  endtask

  // ---------------- stimulus ----------------
  int n;
  int k;

  initial begin
    reset = 1'b1; load = 1'b0; car = 1'b0;
    data_country = 4'd0; data_yellow = 4'd0;
    #1 reset = 1'b0;
    #1;
    check("reset_state", int'(state), 0);
    check("reset_highway", int'(highway_light), 1);
    check("reset_country", int'(country_light), 4);
    check("reset_time", int'(current_time), 0);
    @(posedge clock); #2;
    reset = 1'b1;

    // HG hold with no car: time climbs one second per 4 cycles, then saturates
    step(40);
    check("hg_hold_state", int'(state), 0);
    check("hg_hold_time40", int'(current_time), 10);
    step(30);
    check("hg_hold_time_sat", int'(current_time), 15);

    // Full cycle with the car present throughout
    car = 1'b1;
    wait_state(2'b01, 20, n); check("hg_to_hy_latency", n, 3);
    wait_state(2'b11, 30, n); check("hy_cycles", n, 13);
    wait_state(2'b10, 40, n); check("sg_cycles", n, 21);
    wait_state(2'b00, 30, n); check("sy_cycles", n, 13);
    wait_state(2'b01, 30, n); check("hg_min_cycles", n, 9);

    // Early release in SG
    wait_state(2'b11, 30, n); check("hy_cycles_2", n, 13);
    step(4);
    check("sg_time_at_drop", int'(current_time), 1);
    car = 1'b0;
    wait_state(2'b10, 10, n); check("early_release", n, 3);

    // Deferred load of a zero yellow during HG
    wait_state(2'b00, 30, n); check("sy_cycles_2", n, 13);
    load = 1'b1; data_country = 4'd5; data_yellow = 4'd0; car = 1'b1;
    step(1);
    load = 1'b0;
    wait_state(2'b01, 30, n); check("hg_after_load", n + 1, 9);
    wait_state(2'b11, 30, n); check("hy_short", n, 5);
    car = 1'b0;
    wait_state(2'b10, 10, n); check("sg_drop_2", n, 3);
    wait_state(2'b00, 20, n); check("sy_short", n, 5);

    // Collision: time the car so the transition lands on a tick
    step(12);
    k = 0;
    while (((m_cycles % TICK) != 1) && (k < 8)) begin
      step(1);
      k++;
    end
    car = 1'b1;
    step(3);
    check("collision_state", int'(state), 1);
    check("collision_time0", int'(current_time), 0);
    step(3);
    check("collision_time_hold", int'(current_time), 0);
    step(1);
    check("collision_time1", int'(current_time), 1);

    // Asynchronous reset in the middle of SG
    wait_state(2'b11, 20, n);
    step(2);
    reset = 1'b0;
    #1;
    check("midsg_reset_state", int'(state), 0);
    check("midsg_reset_highway", int'(highway_light), 1);
    check("midsg_reset_country", int'(country_light), 4);
    check("midsg_reset_time", int'(current_time), 0);
    step(1);
    reset = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) car = ~car;
      load = ($urandom_range(0, 19) == 0);
      data_country = 4'($urandom_range(0, 15));
      data_yellow  = 4'($urandom_range(0, 6));
      if (i == 1500) begin
        reset = 1'b0;
        #1 reset = 1'b1;
      end
      step(1);
    end
    load = 1'b0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
